// File: rtl/giu_err_pkg.sv
// Shared types and helpers for the GIU ECC error-log controller.
package giu_err_pkg;

  localparam int GIU_NUM_SRC = 2;
  localparam int GIU_ADDR_W  = 20;
  localparam int GIU_CNT_W   = 16;
  localparam int GIU_THRES_W = 10;
  localparam int GIU_SRC_W   = (GIU_NUM_SRC > 1) ? $clog2(GIU_NUM_SRC) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOG_C  = 2'd1,
    LOG_UC = 2'd2
  } log_state_e;

  typedef struct packed {
    logic                  uc;
    logic [GIU_SRC_W-1:0]  src;
    logic [GIU_ADDR_W-1:0] addr;
  } err_evt_t;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/giu_rr_arb.sv
// Round-robin arbiter: one-hot grant, pointer advances past the winner on each grant.
module giu_rr_arb #(
  parameter int NUM_SRC = 2,
  localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    idx     = '0;
    // Scan from the pointer upwards, wrapping, and take the first requester.
    for (int i = 0; i < NUM_SRC; i++) begin
      sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_SRC)) sum = sum - (IDX_W+1)'(NUM_SRC);
      idx = sum[IDX_W-1:0];
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
    gnt   = gnt_vld ? (NUM_SRC'(1) << gnt_idx) : '0;
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (gnt_idx == IDX_W'(NUM_SRC-1)) ? '0 : gnt_idx + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/giu_err_log_ctrl.sv
// Arbitrates ECC error events into one log entry, saturating C/UC counters,
// a sticky correctable-threshold fault and the IRQ_C / IRQ_UC lines.
module giu_err_log_ctrl
  import giu_err_pkg::*;
#(
  parameter int NUM_SRC = GIU_NUM_SRC,
  parameter int ADDR_W  = GIU_ADDR_W,
  parameter int CNT_W   = GIU_CNT_W,
  parameter int THRES_W = GIU_THRES_W,
  localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_vld,
  output logic [NUM_SRC-1:0]        src_rdy,
  input  logic [NUM_SRC-1:0]        src_uc,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic                      csr_cerr_en,
  input  logic                      csr_uerr_en,
  input  logic [THRES_W-1:0]        csr_thres,
  input  logic                      csr_clr,
  output logic                      log_vld,
  output logic                      log_uc,
  output logic [SRC_W-1:0]          log_src,
  output logic [ADDR_W-1:0]         log_addr,
  output logic                      log_ovf,
  output logic [CNT_W-1:0]          cerr_cnt,
  output logic [CNT_W-1:0]          uerr_cnt,
  output logic                      cerr_thr_fault,
  output logic                      irq_c,
  output logic                      irq_uc
);

  localparam int CMP_W = (CNT_W > THRES_W) ? CNT_W : THRES_W;

  log_state_e       state_q, state_d;
  err_evt_t         log_q, log_d, evt;
  logic             ovf_q, ovf_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cerr_q, cerr_d, uerr_q, uerr_d;
  logic [SRC_W-1:0] gnt_idx;
  logic             gnt_vld;

  giu_rr_arb #(.NUM_SRC(NUM_SRC)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (src_vld),
    .gnt     (src_rdy),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    evt     = '0;
    evt.src = gnt_idx;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (src_rdy[s]) begin
        evt.uc   = src_uc[s];
        evt.addr = src_addr[s*ADDR_W +: ADDR_W];
      end
    end
  end

  // A clear wipes state first; a same-cycle accept then lands as the first event.
  always_comb begin
    state_d = csr_clr ? IDLE : state_q;
    log_d   = csr_clr ? '0   : log_q;
    ovf_d   = csr_clr ? 1'b0 : ovf_q;
    fault_d = csr_clr ? 1'b0 : fault_q;
    cerr_d  = csr_clr ? '0   : cerr_q;
    uerr_d  = csr_clr ? '0   : uerr_q;
    if (gnt_vld) begin
      if (evt.uc) begin
        uerr_d = CNT_W'(sat_inc(32'(uerr_d), CNT_W));
      end else begin
        cerr_d = CNT_W'(sat_inc(32'(cerr_d), CNT_W));
        if ((csr_thres != '0) && (CMP_W'(cerr_d) >= CMP_W'(csr_thres))) fault_d = 1'b1;
      end
      case (state_d)
        IDLE: begin
          state_d = evt.uc ? LOG_UC : LOG_C;
          log_d   = evt;
        end
        LOG_C: begin
          ovf_d = 1'b1;
          if (evt.uc) begin
            state_d = LOG_UC;
            log_d   = evt;
          end
        end
        default: ovf_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      log_q   <= '0;
      ovf_q   <= 1'b0;
      fault_q <= 1'b0;
      cerr_q  <= '0;
      uerr_q  <= '0;
    end else begin
      state_q <= state_d;
      log_q   <= log_d;
      ovf_q   <= ovf_d;
      fault_q <= fault_d;
      cerr_q  <= cerr_d;
      uerr_q  <= uerr_d;
    end
  end

  assign log_vld        = (state_q != IDLE);
  assign log_uc         = (state_q == LOG_UC);
  assign log_src        = SRC_W'(log_q.src);
  assign log_addr       = ADDR_W'(log_q.addr);
  assign log_ovf        = ovf_q;
  assign cerr_cnt       = cerr_q;
  assign uerr_cnt       = uerr_q;
  assign cerr_thr_fault = fault_q;
  assign irq_c          = fault_q & csr_cerr_en;
  assign irq_uc         = (state_q == LOG_UC) & csr_uerr_en;

endmodule

// File: tb/tb_giu_err_log_ctrl.sv
// Scoreboard bench for giu_err_log_ctrl: a behavioural model pushes expected
// outputs each driven cycle; they are popped and compared after the clock edge.
module tb_giu_err_log_ctrl;

  logic        clk;
  logic        reset;
  logic [1:0]  src_vld, src_rdy, src_uc;
  logic [39:0] src_addr;
  logic        csr_cerr_en, csr_uerr_en, csr_clr;
  logic [9:0]  csr_thres;
  logic        log_vld, log_uc, log_ovf, cerr_thr_fault, irq_c, irq_uc;
  logic [0:0]  log_src;
  logic [19:0] log_addr;
  logic [15:0] cerr_cnt, uerr_cnt;

  giu_err_log_ctrl dut (
    .clk(clk), .reset(reset), .src_vld(src_vld), .src_rdy(src_rdy), .src_uc(src_uc),
    .src_addr(src_addr), .csr_cerr_en(csr_cerr_en), .csr_uerr_en(csr_uerr_en),
    .csr_thres(csr_thres), .csr_clr(csr_clr), .log_vld(log_vld), .log_uc(log_uc),
    .log_src(log_src), .log_addr(log_addr), .log_ovf(log_ovf), .cerr_cnt(cerr_cnt),
    .uerr_cnt(uerr_cnt), .cerr_thr_fault(cerr_thr_fault), .irq_c(irq_c), .irq_uc(irq_uc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int vld, uc, src, addr, ovf, cc, ucnt, flt, irqc, irquc;
  } exp_t;

  exp_t q_exp[$];
  int   n_chk = 0, n_pass = 0;
  int   last_gnt = -1;
  // model state: m_state 0=IDLE 1=LOG_C 2=LOG_UC
  int   m_ptr = 0, m_state = 0, m_src = 0, m_addr = 0, m_ovf = 0;
  int   m_cc = 0, m_ucnt = 0, m_flt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic model_clear();
    m_state = 0; m_src = 0; m_addr = 0; m_ovf = 0; m_cc = 0; m_ucnt = 0; m_flt = 0;
  endtask

  task automatic model_event(input int g, input int uc, input int a);
    if (uc != 0) begin
      if (m_ucnt < 65535) m_ucnt++;
    end else begin
      if (m_cc < 65535) m_cc++;
      if (csr_thres != 0 && m_cc >= int'(csr_thres)) m_flt = 1;
    end
    case (m_state)
      0: begin m_state = (uc != 0) ? 2 : 1; m_src = g; m_addr = a; end
      1: begin m_ovf = 1; if (uc != 0) begin m_state = 2; m_src = g; m_addr = a; end end
      default: m_ovf = 1;
    endcase
  endtask

  // One clock: check the combinational grant, update model, push, clock, pop, compare.
  task automatic step();
    int   g;
    exp_t e;
    #1;
    g = -1;
    for (int k = 0; k < 2; k++) begin
      int idx;
      idx = (m_ptr + k) % 2;
      if (g < 0 && src_vld[idx]) g = idx;
    end
    chk("src_rdy", 32'(src_rdy), (g < 0) ? 32'd0 : (32'd1 << g));
    if (reset) begin
      model_clear();
      m_ptr = 0;
    end else begin
      if (csr_clr) model_clear();
      if (g >= 0) begin
        model_event(g, int'(src_uc[g]), int'(src_addr[g*20 +: 20]));
        m_ptr = (g + 1) % 2;
      end
    end
    e.vld = (m_state != 0); e.uc = (m_state == 2); e.src = m_src; e.addr = m_addr;
    e.ovf = m_ovf; e.cc = m_cc; e.ucnt = m_ucnt; e.flt = m_flt;
    e.irqc = m_flt & int'(csr_cerr_en); e.irquc = (m_state == 2) & int'(csr_uerr_en);
    q_exp.push_back(e);
    last_gnt = g;
    @(posedge clk);
    #1;
    e = q_exp.pop_front();
    chk("log_vld", 32'(log_vld), 32'(e.vld));
    chk("log_uc", 32'(log_uc), 32'(e.uc));
    chk("log_src", 32'(log_src), 32'(e.src));
    chk("log_addr", 32'(log_addr), 32'(e.addr));
    chk("log_ovf", 32'(log_ovf), 32'(e.ovf));
    chk("cerr_cnt", 32'(cerr_cnt), 32'(e.cc));
    chk("uerr_cnt", 32'(uerr_cnt), 32'(e.ucnt));
    chk("cerr_thr_fault", 32'(cerr_thr_fault), 32'(e.flt));
    chk("irq_c", 32'(irq_c), 32'(e.irqc));
    chk("irq_uc", 32'(irq_uc), 32'(e.irquc));
  endtask

  task automatic send(input int s, input logic uc, input logic [19:0] a);
    int n;
    n = 0;
    src_vld[s] = 1'b1;
    src_uc[s]  = uc;
    src_addr[s*20 +: 20] = a;
    do begin
      step();
      n++;
    end while (last_gnt != s && n < 8);
    chk("send_grant", 32'(last_gnt), 32'(s));
    src_vld[s] = 1'b0;
  endtask

  initial begin
    int gseq[4];
    reset = 1'b1; src_vld = '0; src_uc = '0; src_addr = '0;
    csr_cerr_en = 1'b0; csr_uerr_en = 1'b0; csr_thres = '0; csr_clr = 1'b0;
    step();
    step();
    chk("rst_log_vld", 32'(log_vld), 32'd0);
    chk("rst_cerr", 32'(cerr_cnt), 32'd0);
    chk("rst_irq_uc", 32'(irq_uc), 32'd0);
    reset = 1'b0;
    step();

    // first correctable event
    csr_thres = 10'd3; csr_cerr_en = 1'b1; csr_uerr_en = 1'b1;
    send(0, 1'b0, 20'h00100);
    chk("t1_log_vld", 32'(log_vld), 32'd1);
    chk("t1_log_uc", 32'(log_uc), 32'd0);
    chk("t1_log_src", 32'(log_src), 32'd0);
    chk("t1_cerr", 32'(cerr_cnt), 32'd1);
    chk("t1_irq_c", 32'(irq_c), 32'd0);

    // threshold reached, log keeps first entry
    send(1, 1'b0, 20'h00111);
    send(0, 1'b0, 20'h00122);
    chk("t2_cerr", 32'(cerr_cnt), 32'd3);
    chk("t2_fault", 32'(cerr_thr_fault), 32'd1);
    chk("t2_irq_c", 32'(irq_c), 32'd1);
    chk("t2_ovf", 32'(log_ovf), 32'd1);
    chk("t2_addr", 32'(log_addr), 32'h100);
    csr_cerr_en = 1'b0;
    step();
    chk("t2_irq_c_gated", 32'(irq_c), 32'd0);
    csr_cerr_en = 1'b1;

    // reset mid-operation returns the pointer to source 0
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_log_vld", 32'(log_vld), 32'd0);
    chk("rst2_fault", 32'(cerr_thr_fault), 32'd0);

    // both sources uncorrectable, held every cycle
    src_vld = 2'b11; src_uc = 2'b11; src_addr = {20'h00301, 20'h00300};
    for (int i = 0; i < 4; i++) begin
      step();
      gseq[i] = last_gnt;
    end
    src_vld = '0;
    chk("t3_g0", 32'(gseq[0]), 32'd0);
    chk("t3_g1", 32'(gseq[1]), 32'd1);
    chk("t3_g2", 32'(gseq[2]), 32'd0);
    chk("t3_g3", 32'(gseq[3]), 32'd1);
    chk("t3_uerr", 32'(uerr_cnt), 32'd4);
    chk("t3_log_src", 32'(log_src), 32'd0);
    chk("t3_log_addr", 32'(log_addr), 32'h300);
    chk("t3_irq_uc", 32'(irq_uc), 32'd1);
    csr_uerr_en = 1'b0;
    step();
    chk("t3_irq_uc_gated", 32'(irq_uc), 32'd0);
    csr_uerr_en = 1'b1;

    // LOG_C promoted by a later UC
    csr_clr = 1'b1;
    step();
    csr_clr = 1'b0;
    csr_thres = 10'd1;
    send(0, 1'b0, 20'h00050);
    send(1, 1'b1, 20'h002AB);
    chk("t4_log_uc", 32'(log_uc), 32'd1);
    chk("t4_log_src", 32'(log_src), 32'd1);
    chk("t4_log_addr", 32'(log_addr), 32'h2AB);
    chk("t4_ovf", 32'(log_ovf), 32'd1);
    chk("t4_fault", 32'(cerr_thr_fault), 32'd1);

    // clear coincident with an accept
    csr_thres = 10'd3;
    csr_clr = 1'b1;
    send(0, 1'b0, 20'h00155);
    csr_clr = 1'b0;
    chk("t5_log_vld", 32'(log_vld), 32'd1);
    chk("t5_log_uc", 32'(log_uc), 32'd0);
    chk("t5_log_addr", 32'(log_addr), 32'h155);
    chk("t5_cerr", 32'(cerr_cnt), 32'd1);
    chk("t5_uerr", 32'(uerr_cnt), 32'd0);
    chk("t5_fault", 32'(cerr_thr_fault), 32'd0);
    chk("t5_ovf", 32'(log_ovf), 32'd0);

    // lowering threshold alone does not fault; the next C event does
    send(1, 1'b0, 20'h00166);
    csr_thres = 10'd1;
    step();
    chk("thr_low_nofault", 32'(cerr_thr_fault), 32'd0);
    send(0, 1'b0, 20'h00177);
    chk("thr_low_fault", 32'(cerr_thr_fault), 32'd1);

    // saturation with threshold disabled
    csr_clr = 1'b1;
    step();
    csr_clr = 1'b0;
    csr_thres = 10'd0;
    src_vld[0] = 1'b1; src_uc[0] = 1'b0;
    for (int i = 0; i < 65534; i++) step();
    chk("t6_cerr_fffe", 32'(cerr_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) step();
    src_vld = '0;
    chk("t6_cerr_sat", 32'(cerr_cnt), 32'hFFFF);
    chk("t6_fault", 32'(cerr_thr_fault), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
